// File: rtl/serial_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with a start/busy/done handshake and results held until the next completion.
module serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_raw;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic             w_unused_msb;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_dvs_zero;
  logic             w_load;

  assign w_dvd_abs  = (i_signed_op && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_dvs_abs  = (i_signed_op && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
  assign w_dvs_zero = (i_divisor == '0);

  // Subtract as add of the inverted divisor plus one; the carry out is R' >= |divisor|.
  // When the subtract is taken the difference is below the divisor, so its top bit is 0.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign {w_ge, w_unused_msb, w_diff} = {1'b0, w_shift} + {1'b0, ~{1'b0, r_dvs}}
                                       + {{(WIDTH+1){1'b0}}, 1'b1};

  assign w_load = (r_state == S_FIX) && (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_next = w_dvs_zero ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_next = S_FIX;
      S_FIX:   if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_raw         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (i_start) begin
          r_rem   <= '0;
          r_quo   <= w_dvd_abs;
          r_dvs   <= w_dvs_abs;
          r_raw   <= i_dividend;
          r_q_neg <= i_signed_op && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
          r_r_neg <= i_signed_op && i_dividend[WIDTH-1];
          r_dz    <= w_dvs_zero;
          // A zero divisor waits two cycles in FIX so its latency stays fixed at 3.
          r_cnt   <= w_dvs_zero ? CW'(1) : CW'(WIDTH - 1);
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase

      if (w_load) begin
        if (r_dz) begin
          r_quotient    <= '1;
          r_remainder   <= r_raw;
          r_div_by_zero <= 1'b1;
        end else begin
          r_quotient    <= r_q_neg ? -r_quo : r_quo;
          r_remainder   <= r_r_neg ? -r_rem : r_rem;
          r_div_by_zero <= 1'b0;
        end
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_serial_divider.sv
// Directed vector table plus hand-written busy/reset/back-to-back sequences
// and a randomized comparison against a behavioural divide model.
module tb_serial_divider;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic        i_signed_op;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  serial_divider #(.WIDTH(32)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_signed_op  (i_signed_op),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One divide: start in cycle 0, optional extra start pulse in cycle 'poke'.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int lat, output logic busy_ok);
    i_signed_op = sgn;
    i_dividend  = a;
    i_divisor   = b;
    i_start     = 1'b1;
    tick();
    i_start    = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    lat        = 0;
    busy_ok    = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (c == poke) begin
        i_start    = 1'b1;
        i_dividend = 32'd1000;
        i_divisor  = 32'd3;
      end else
        i_start = 1'b0;
      if (!o_busy) busy_ok = 1'b0;
      if (o_done) begin
        lat = c;
        break;
      end
      tick();
    end
    i_start = 1'b0;
    q  = o_quotient;
    r  = o_remainder;
    dz = o_div_by_zero;
    tick();
    if (o_busy || o_done) busy_ok = 1'b0;
  endtask

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 3;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0; lat = 34;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = 34;
    end
  endtask

  initial begin
    logic [31:0] q, r, eq, er;
    logic        dz, edz, bok, hold_ok, sgn;
    logic [31:0] a, b;
    int          lat, elat, ndone, lat2;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34};
    vecs[3] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 34};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
    vecs[6] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 3};
    vecs[7] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 3};
    vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34};
    vecs[9] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0, 34};

    i_rst = 1'b1; i_start = 1'b0; i_signed_op = 1'b0; i_dividend = '0; i_divisor = '0;
    tick(); tick();
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_quotient", o_quotient, 32'd0);
    chk("reset_remainder", o_remainder, 32'd0);
    chk("reset_dz", 32'(o_div_by_zero), 32'd0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, q, r, dz, lat, bok);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_window", i), 32'(bok), 32'd1);
    end

    // Start pulse in cycle 10 of an active divide must be dropped.
    do_op(1'b0, 32'd100, 32'd7, 10, q, r, dz, lat, bok);
    chk("poke_quotient", q, 32'd14);
    chk("poke_remainder", r, 32'd2);
    chk("poke_latency", 32'(lat), 32'd34);
    hold_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (o_busy || o_done || o_quotient != 32'd14 || o_remainder != 32'd2) hold_ok = 1'b0;
      tick();
    end
    chk("poke_hold", 32'(hold_ok), 32'd1);

    // Reset in cycle 15 of a divide.
    i_signed_op = 1'b0; i_dividend = 32'd999; i_divisor = 32'd4; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (14) tick();
    i_rst = 1'b1;
    #1;
    chk("midrst_quotient", o_quotient, 32'd0);
    chk("midrst_remainder", o_remainder, 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    tick();
    i_rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done || o_busy) ndone++;
      tick();
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_op(1'b0, 32'd50, 32'd5, 0, q, r, dz, lat, bok);
    chk("after_rst_quotient", q, 32'd10);
    chk("after_rst_remainder", r, 32'd0);

    // Start held high: second operation captures operands present at its own start.
    i_signed_op = 1'b0; i_dividend = 32'd20; i_divisor = 32'd3; i_start = 1'b1;
    lat = 0; lat2 = 0; q = '0; r = '0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 5) begin i_dividend = 32'd90; i_divisor = 32'd9; end
      if (c == 36) i_start = 1'b0;
      if (o_done && lat == 0) begin
        lat = c; q = o_quotient; r = o_remainder;
      end else if (o_done) begin
        lat2 = c;
        break;
      end
    end
    i_start = 1'b0;
    chk("b2b_first_quotient", q, 32'd6);
    chk("b2b_first_remainder", r, 32'd2);
    chk("b2b_first_latency", 32'(lat), 32'd34);
    chk("b2b_second_quotient", o_quotient, 32'd10);
    chk("b2b_second_remainder", o_remainder, 32'd0);
    chk("b2b_second_latency", 32'(lat2), 32'd69);
    tick();

    for (int i = 0; i < 1000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(sgn, a, b, eq, er, edz, elat);
      do_op(sgn, a, b, 0, q, r, dz, lat, bok);
      chk($sformatf("rnd%0d_q %h/%h s%0d", i, a, b, sgn), q, eq);
      chk($sformatf("rnd%0d_r", i), r, er);
      chk($sformatf("rnd%0d_dz_lat", i), {31'd0, dz} + 32'(lat), {31'd0, edz} + 32'(elat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
